// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: peripheral request lines, register bus and core-side interrupt outputs of irq_ctrl.
interface irq_ctrl_if #(parameter int NSRC = 5);
  logic [NSRC-1:0] irq_src;
  logic            we;
  logic [1:0]      a;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic [NSRC-1:0] INT;
  logic [2:0]      active_id;
  logic            busy;
  modport master (output irq_src, we, a, wd, input rd, INT, active_id, busy);
  modport slave (input irq_src, we, a, wd, output rd, INT, active_id, busy);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller driving the MIPS core's one-hot INT input.
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer on every irq_src bit.
module irq_ctrl #(
  parameter int         NSRC       = 5,
  parameter logic [4:0] LEVEL_MASK = 5'b00000,
  parameter logic [4:0] ENABLE_RST = 5'b00000
) (
  input  logic       clk,
  input  logic       rst,
  irq_ctrl_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;
  localparam logic [NSRC-1:0] LVL = LEVEL_MASK[NSRC-1:0];
  localparam logic [NSRC-1:0] ENR = ENABLE_RST[NSRC-1:0];
  logic [NSRC-1:0] src, set, clr, req, onehot;
  logic [NSRC-1:0] prev_q, prev_d, pend_q, pend_d, en_q, en_d;
  logic [1:0]      state_q, state_d;
  logic [2:0]      id_q, id_d, win;
  logic            eoi, unused_wd;
`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  always_comb begin
    sync1_d = bus.irq_src;
    sync2_d = sync1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign src = sync2_q;
`else
  assign src = bus.irq_src;
`endif
  assign unused_wd = ^bus.wd[31:NSRC];
  assign onehot    = NSRC'(1) << id_q;
  // lowest index wins: scan downward so the last hit is the smallest
  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (req[i]) win = 3'(i);
  end
  always_comb begin
    req     = pend_q & en_q;
    eoi     = bus.we && bus.a == 2'd2 && state_q == ASSERT;
    set     = src & (LVL | ~prev_q);
    clr     = (bus.we && bus.a == 2'd0 ? bus.wd[NSRC-1:0] : '0) | (eoi ? onehot : '0);
    pend_d  = (pend_q & ~clr) | set;
    en_d    = bus.we && bus.a == 2'd1 ? bus.wd[NSRC-1:0] : en_q;
    prev_d  = src;
    state_d = state_q == IDLE   ? (|req ? ASSERT : IDLE) :
              state_q == ASSERT ? (eoi ? GAP : ASSERT) : IDLE;
    id_d    = state_q == IDLE && |req ? win : id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      en_q    <= ENR;
      prev_q  <= '0;
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      pend_q  <= pend_d;
      en_q    <= en_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      id_q    <= id_d;
    end
  end
  always_comb begin
    bus.busy      = state_q == ASSERT;
    bus.INT       = bus.busy ? onehot : '0;
    bus.active_id = bus.busy ? id_q : 3'd0;
    bus.rd        = bus.a == 2'd0 ? 32'(pend_q) :
                    bus.a == 2'd1 ? 32'(en_q) :
                    bus.a == 2'd3 ? {26'b0, state_q, bus.busy, bus.active_id} : 32'd0;
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: vector table, directed corner sequences and random traffic against a reference model.
module tb_irq_ctrl;
  localparam int N = 5;
  localparam logic [4:0] LM = 5'h10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  irq_ctrl_if #(.NSRC(N)) bus ();
  irq_ctrl #(.NSRC(N), .LEVEL_MASK(LM), .ENABLE_RST(5'h00)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] m_pend, m_en, m_prev, m_s1, m_s2;
  int m_gnt = -1;
  int m_gap = 0;
  typedef struct {
    logic        rst;
    logic [4:0]  irq;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [4:0]  e_int;
    logic [31:0] e_rd;
  } vec_t;
  vec_t tbl[15];

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_int();
    return m_gnt >= 0 ? 5'(1 << m_gnt) : 5'd0;
  endfunction

  function automatic logic [31:0] m_rd(logic [1:0] a);
    int st = m_gnt >= 0 ? 1 : (m_gap != 0 ? 2 : 0);
    int id = m_gnt >= 0 ? m_gnt : 0;
    int bz = m_gnt >= 0 ? 1 : 0;
    if (a == 2'd0) return {27'b0, m_pend};
    if (a == 2'd1) return {27'b0, m_en};
    if (a == 2'd2) return 32'd0;
    return 32'(st * 16 + bz * 8 + id);
  endfunction

  task automatic model_step();
    logic [4:0] src, set, clr, lm;
    int win;
    if (rst) begin
      m_pend = '0; m_en = 5'h00; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_gnt = -1; m_gap = 0;
      return;
    end
`ifdef IRQ_SYNC_EN
    src = m_s2; m_s2 = m_s1; m_s1 = bus.irq_src;
`else
    src = bus.irq_src;
`endif
    lm = LM;
    set = '0;
    for (int i = 0; i < N; i++) if (src[i] && (lm[i] || !m_prev[i])) set[i] = 1'b1;
    clr = (bus.we && bus.a == 2'd0) ? bus.wd[4:0] : 5'd0;
    win = -1;
    if (m_gnt >= 0) begin
      if (bus.we && bus.a == 2'd2) begin
        clr[m_gnt] = 1'b1;
        m_gnt = -1;
        m_gap = 1;
      end
    end else if (m_gap != 0) m_gap = 0;
    else begin
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
      m_gnt = win;
    end
    m_pend = (m_pend & ~clr) | set;
    if (bus.we && bus.a == 2'd1) m_en = bus.wd[4:0];
    m_prev = src;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp("model_INT", 32'(bus.INT), 32'(m_int()));
    cmp("model_active_id", 32'(bus.active_id), m_gnt >= 0 ? 32'(m_gnt) : 32'd0);
    cmp("model_busy", 32'(bus.busy), m_gnt >= 0 ? 32'd1 : 32'd0);
    cmp("model_rd", bus.rd, m_rd(bus.a));
  endtask

  task automatic drive(logic [4:0] irq, logic w, logic [1:0] aa, logic [31:0] d);
    bus.irq_src = irq;
    bus.we = w;
    bus.a = aa;
    bus.wd = d;
  endtask

  task automatic wait_int(logic [4:0] exp, int max, string name);
    int k = 0;
    while (bus.INT !== exp && k < max) begin
      tick();
      k++;
    end
    cmp(name, 32'(bus.INT), 32'(exp));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'h00, 1'b0, 2'd0, 32'h0, 5'h00, 32'h00};
    tbl[1]  = '{1'b1, 5'h00, 1'b0, 2'd3, 32'h0, 5'h00, 32'h00};
    tbl[2]  = '{1'b0, 5'h00, 1'b1, 2'd1, 32'h4, 5'h00, 32'h04};
    tbl[3]  = '{1'b0, 5'h04, 1'b0, 2'd0, 32'h0, 5'h00, 32'h04};
    tbl[4]  = '{1'b0, 5'h00, 1'b0, 2'd3, 32'h0, 5'h04, 32'h1A};
    tbl[5]  = '{1'b0, 5'h00, 1'b0, 2'd0, 32'h0, 5'h04, 32'h04};
    tbl[6]  = '{1'b0, 5'h00, 1'b1, 2'd2, 32'h0, 5'h00, 32'h00};
    tbl[7]  = '{1'b0, 5'h00, 1'b0, 2'd0, 32'h0, 5'h00, 32'h00};
    tbl[8]  = '{1'b0, 5'h00, 1'b1, 2'd1, 32'h0, 5'h00, 32'h00};
    tbl[9]  = '{1'b0, 5'h02, 1'b0, 2'd0, 32'h0, 5'h00, 32'h02};
    tbl[10] = '{1'b0, 5'h00, 1'b0, 2'd0, 32'h0, 5'h00, 32'h02};
    tbl[11] = '{1'b0, 5'h00, 1'b1, 2'd1, 32'h2, 5'h00, 32'h02};
    tbl[12] = '{1'b0, 5'h00, 1'b0, 2'd0, 32'h0, 5'h02, 32'h02};
    tbl[13] = '{1'b0, 5'h00, 1'b1, 2'd2, 32'h0, 5'h00, 32'h00};
    tbl[14] = '{1'b0, 5'h00, 1'b0, 2'd0, 32'h0, 5'h00, 32'h00};
    drive(5'h00, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].irq, tbl[i].we, tbl[i].a, tbl[i].wd);
      tick();
      cmp($sformatf("tbl%0d_INT", i), 32'(bus.INT), 32'(tbl[i].e_int));
      cmp($sformatf("tbl%0d_rd", i), bus.rd, tbl[i].e_rd);
    end
    // grant held for 20 cycles, then exactly one GAP cycle
    drive(5'h00, 1'b1, 2'd1, 32'h4); tick();
    drive(5'h04, 1'b0, 2'd0, 32'h0); tick();
    cmp("t1_pending", bus.rd, 32'h04);
    drive(5'h00, 1'b0, 2'd0, 32'h0); tick();
    repeat (20) begin
      tick();
      cmp("t1_hold", 32'(bus.INT), 32'h04);
    end
    drive(5'h00, 1'b1, 2'd2, 32'h0); tick();
    cmp("t1_eoi_drop", 32'(bus.INT), 32'h00);
    drive(5'h00, 1'b0, 2'd3, 32'h0); #1;
    cmp("t1_gap_status", bus.rd, 32'h20);
    tick();
    cmp("t1_idle_status", bus.rd, 32'h00);
    // higher priority arrival does not preempt
    drive(5'h00, 1'b1, 2'd1, 32'h1F); tick();
    drive(5'h08, 1'b0, 2'd0, 32'h0);
    wait_int(5'h08, 10, "t2_grant3");
    drive(5'h09, 1'b0, 2'd0, 32'h0);
    repeat (5) begin
      tick();
      cmp("t2_nopreempt", 32'(bus.INT), 32'h08);
    end
    drive(5'h09, 1'b1, 2'd2, 32'h0); tick();
    cmp("t2_gap", 32'(bus.INT), 32'h00);
    drive(5'h09, 1'b0, 2'd0, 32'h0);
    wait_int(5'h01, 5, "t2_grant0");
    drive(5'h00, 1'b1, 2'd2, 32'h0); tick();
    drive(5'h00, 1'b0, 2'd0, 32'h0); tick(); tick();
    // W1C racing a new edge: set wins
    drive(5'h00, 1'b1, 2'd1, 32'h0); tick();
    drive(5'h01, 1'b1, 2'd0, 32'h1); tick();
    drive(5'h01, 1'b0, 2'd0, 32'h0); #1;
    cmp("t4_race", bus.rd, 32'h01);
    drive(5'h01, 1'b1, 2'd0, 32'h1); tick();
    drive(5'h01, 1'b0, 2'd0, 32'h0); #1;
    cmp("t4_clear", bus.rd, 32'h00);
    drive(5'h00, 1'b0, 2'd0, 32'h0); tick();
    // level source re-granted after GAP
    drive(5'h00, 1'b1, 2'd1, 32'h10); tick();
    drive(5'h10, 1'b0, 2'd0, 32'h0);
    wait_int(5'h10, 5, "t5_grant4");
    drive(5'h10, 1'b1, 2'd2, 32'h0); tick();
    cmp("t5_gap", 32'(bus.INT), 32'h00);
    drive(5'h10, 1'b0, 2'd0, 32'h0); tick();
    cmp("t5_idle", 32'(bus.INT), 32'h00);
    tick();
    cmp("t5_regrant", 32'(bus.INT), 32'h10);
    drive(5'h00, 1'b0, 2'd0, 32'h0); tick();
    drive(5'h00, 1'b1, 2'd2, 32'h0); tick();
    cmp("t5_eoi", 32'(bus.INT), 32'h00);
    drive(5'h00, 1'b0, 2'd0, 32'h0);
    repeat (4) begin
      tick();
      cmp("t5_stay_idle", 32'(bus.INT), 32'h00);
    end
    cmp("t5_pending", bus.rd, 32'h00);
    // reset while busy, then EOI while idle
    drive(5'h00, 1'b1, 2'd1, 32'h4); tick();
    drive(5'h04, 1'b0, 2'd0, 32'h0); tick();
    drive(5'h00, 1'b0, 2'd0, 32'h0); tick();
    cmp("t6_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    cmp("t6_rst_INT", 32'(bus.INT), 32'h00);
    cmp("t6_rst_pending", bus.rd, 32'h00);
    drive(5'h00, 1'b0, 2'd3, 32'h0); #1;
    cmp("t6_rst_status", bus.rd, 32'h00);
    drive(5'h00, 1'b1, 2'd2, 32'h0); tick();
    drive(5'h00, 1'b0, 2'd3, 32'h0); #1;
    cmp("t6_eoi_idle_status", bus.rd, 32'h00);
    cmp("t6_eoi_idle_INT", 32'(bus.INT), 32'h00);
    // random traffic against the model
    repeat (600) begin
      rst = $urandom_range(0, 199) == 0;
      drive(5'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), $urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
